vregfile_rdport_arb: RTL and testbench

- Shares the single registered-address read port of a 1R/1W vector register file between two read requesters (R0, R1) using round-robin arbitration.
- Passes the single write requester straight through to the write port.
- Tags each read response with the ID of the requester that issued it.
- Forwards same-cycle write data, because the RAM returns OLD_DATA on a mixed-port collision. Sits between lane operand-fetch logic and the register file RAM.

---
 rtl/vregfile_rdport_arb_if.sv | 39 +++
 rtl/vregfile_rdport_arb.sv | 101 ++++++++++
 tb/tb_vregfile_rdport_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vregfile_rdport_arb_if.sv
// Bundles the read-requester, write-requester, response and register-file RAM
// signals of the read-port arbiter; slave is the arbiter, master its environment.
interface vregfile_rdport_arb_if #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 4
);
  logic                   rd0_req;
  logic [LOG2NUMREGS-1:0] rd0_reg;
  logic                   rd0_gnt;
  logic                   rd1_req;
  logic [LOG2NUMREGS-1:0] rd1_reg;
  logic                   rd1_gnt;
  logic                   wr_en;
  logic [LOG2NUMREGS-1:0] wr_reg;
  logic [WIDTH-1:0]       wr_data;
  logic                   rsp_valid;
  logic                   rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic [LOG2NUMREGS-1:0] rf_a_reg;
  logic                   rf_a_en;
  logic [WIDTH-1:0]       rf_a_readdataout;
  logic [LOG2NUMREGS-1:0] rf_c_reg;
  logic [WIDTH-1:0]       rf_c_writedatain;
  logic                   rf_c_we;

  modport slave (
    input  rd0_req, rd0_reg, rd1_req, rd1_reg,
    input  wr_en, wr_reg, wr_data, rf_a_readdataout,
    output rd0_gnt, rd1_gnt, rsp_valid, rsp_id, rsp_data,
    output rf_a_reg, rf_a_en, rf_c_reg, rf_c_writedatain, rf_c_we
  );

  modport master (
    output rd0_req, rd0_reg, rd1_req, rd1_reg,
    output wr_en, wr_reg, wr_data, rf_a_readdataout,
    input  rd0_gnt, rd1_gnt, rsp_valid, rsp_id, rsp_data,
    input  rf_a_reg, rf_a_en, rf_c_reg, rf_c_writedatain, rf_c_we
  );
endinterface

// File: rtl/vregfile_rdport_arb.sv
// Round-robin sharing of a 1R/1W register file read port between two requesters,
// with write passthrough and same-cycle write forwarding into the 1-cycle response.
module vregfile_rdport_arb #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 16,
  parameter int LOG2NUMREGS = 4
) (
  input logic                 clk,
  input logic                 reset,
  vregfile_rdport_arb_if.slave bus
);

  if (NUMREGS > (1 << LOG2NUMREGS)) begin : g_bad_params
    $error("NUMREGS does not fit in LOG2NUMREGS address bits");
  end

  typedef enum logic {
    PRIO_R0 = 1'b0,
    PRIO_R1 = 1'b1
  } prio_e;

  prio_e            r_prio;
  prio_e            w_prio_nxt;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any_gnt;
  logic             w_fwd;
  logic [WIDTH-1:0] w_rsp_data;

  logic             r_v1;
  logic             r_id1;
  logic             r_fwd1;
  logic [WIDTH-1:0] r_fwdd1;
  logic [WIDTH-1:0] r_last_data;

  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_prio_nxt = r_prio;
    if (!reset) begin
      if (bus.rd0_req && (!bus.rd1_req || r_prio == PRIO_R0)) begin
        w_gnt0 = 1'b1;
      end else if (bus.rd1_req) begin
        w_gnt1 = 1'b1;
      end
    end
    // The winner yields preference to the other requester.
    if (w_gnt0) begin
      w_prio_nxt = PRIO_R1;
    end else if (w_gnt1) begin
      w_prio_nxt = PRIO_R0;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  assign bus.rd0_gnt  = w_gnt0;
  assign bus.rd1_gnt  = w_gnt1;
  assign bus.rf_a_en  = w_any_gnt;
  assign bus.rf_a_reg = w_gnt1 ? bus.rd1_reg : bus.rd0_reg;

  assign bus.rf_c_we          = bus.wr_en & ~reset;
  assign bus.rf_c_reg         = bus.wr_reg;
  assign bus.rf_c_writedatain = bus.wr_data;

  // The RAM returns old data on a same-address read/write, so capture the write.
  assign w_fwd = bus.wr_en & bus.rf_c_we & (bus.wr_reg == bus.rf_a_reg) & bus.rf_a_en;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio      <= PRIO_R0;
      r_v1        <= 1'b0;
      r_id1       <= 1'b0;
      r_fwd1      <= 1'b0;
      r_fwdd1     <= '0;
      r_last_data <= '0;
    end else begin
      r_prio <= w_prio_nxt;
      r_v1   <= w_any_gnt;
      if (w_any_gnt) begin
        r_id1   <= w_gnt1;
        r_fwd1  <= w_fwd;
        r_fwdd1 <= bus.wr_data;
      end
      if (r_v1) begin
        r_last_data <= w_rsp_data;
      end
    end
  end

  // Outside a valid cycle the response bus shows the last delivered value.
  assign w_rsp_data    = r_v1 ? (r_fwd1 ? r_fwdd1 : bus.rf_a_readdataout) : r_last_data;
  assign bus.rsp_valid = r_v1;
  assign bus.rsp_id    = r_id1;
  assign bus.rsp_data  = w_rsp_data;

endmodule

// File: tb/tb_vregfile_rdport_arb.sv
// Bench for vregfile_rdport_arb: behavioural OLD_DATA RAM, directed scenarios,
// then random held-until-granted traffic against a cycle-level reference model.
module tb_vregfile_rdport_arb;

  localparam int WIDTH = 32;
  localparam int L     = 4;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vregfile_rdport_arb_if #(.WIDTH(WIDTH), .LOG2NUMREGS(L)) bus ();

  vregfile_rdport_arb #(.WIDTH(WIDTH), .NUMREGS(N), .LOG2NUMREGS(L)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Registered-read RAM; a read and write to one address in a cycle returns old data.
  logic [WIDTH-1:0] ram [N];
  logic [WIDTH-1:0] ram_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ram[i] <= '0;
      ram_q <= '0;
    end else begin
      if (bus.rf_a_en) ram_q <= ram[bus.rf_a_reg];
      if (bus.rf_c_we) ram[bus.rf_c_reg] <= bus.rf_c_writedatain;
    end
  end
  assign bus.rf_a_readdataout = ram_q;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural register contents, preference bit, pending response.
  logic [WIDTH-1:0] m_regs [N];
  bit               m_prio;
  bit               exp_v;
  bit               exp_id;
  logic [WIDTH-1:0] exp_data;
  bit               last_g0;
  bit               last_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio   = 1'b0;
    exp_v    = 1'b0;
    exp_id   = 1'b0;
    exp_data = '0;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
  endtask

  task automatic drive(input bit r0, input logic [L-1:0] a0, input bit r1, input logic [L-1:0] a1,
                       input bit we, input logic [L-1:0] wa, input logic [WIDTH-1:0] wd);
    bus.rd0_req = r0;
    bus.rd0_reg = a0;
    bus.rd1_req = r1;
    bus.rd1_reg = a1;
    bus.wr_en   = we;
    bus.wr_reg  = wa;
    bus.wr_data = wd;
  endtask

  task automatic check_now();
    bit g0, g1;
    if (rst) model_reset();
    g0 = !rst && bus.rd0_req && (!bus.rd1_req || !m_prio);
    g1 = !rst && bus.rd1_req && (!bus.rd0_req || m_prio);
    last_g0 = g0;
    last_g1 = g1;
    check("rd0_gnt",   bus.rd0_gnt, g0);
    check("rd1_gnt",   bus.rd1_gnt, g1);
    check("rf_a_en",   bus.rf_a_en, g0 | g1);
    check("rf_a_reg",  bus.rf_a_reg, g1 ? bus.rd1_reg : bus.rd0_reg);
    check("rf_c_we",   bus.rf_c_we, bus.wr_en & !rst);
    check("rf_c_reg",  bus.rf_c_reg, bus.wr_reg);
    check("rf_c_data", bus.rf_c_writedatain, bus.wr_data);
    check("rsp_valid", bus.rsp_valid, exp_v);
    check("rsp_id",    bus.rsp_id, exp_id);
    check("rsp_data",  bus.rsp_data, exp_data);
  endtask

  // Apply the clock edge to the model, then move to just after the DUT edge.
  task automatic advance();
    logic [L-1:0] addr;
    if (rst) begin
      model_reset();
    end else begin
      if (last_g0 || last_g1) begin
        addr     = last_g1 ? bus.rd1_reg : bus.rd0_reg;
        exp_v    = 1'b1;
        exp_id   = last_g1;
        exp_data = (bus.wr_en && bus.wr_reg == addr) ? bus.wr_data : m_regs[addr];
        m_prio   = last_g0;
      end else begin
        exp_v = 1'b0;
      end
      if (bus.wr_en) m_regs[bus.wr_reg] = bus.wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit r0, input logic [L-1:0] a0, input bit r1, input logic [L-1:0] a1,
                      input bit we, input logic [L-1:0] wa, input logic [WIDTH-1:0] wd);
    drive(r0, a0, r1, a1, we, wa, wd);
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               q0, q1;
    logic [L-1:0]     a0, a1;
    int               age0, age1;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    model_reset();
    @(posedge clk);
    #1;

    // Held in reset: requests and writes must be suppressed.
    step(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd4, 32'hAAAA5555);
    rst = 1'b0;

    // Grant R0 on reg 3, then reset before the next edge drops the response.
    drive(1'b1, 4'd3, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check_now();
    rst = 1'b1;
    #1;
    check_now();
    advance();
    step(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd3, 32'h12345678);
    rst = 1'b0;

    // Continuous contention from reset: R0, R1, R0, R1.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, '0, '0);
    idle();

    // Single requester reads back an earlier write.
    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd5, 32'hDEADBEEF);
    idle();
    idle();
    step(1'b0, '0, 1'b1, 4'd5, 1'b0, '0, '0);
    idle();

    // Same-cycle write/read of reg 7 is forwarded.
    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd7, 32'h11111111);
    step(1'b1, 4'd7, 1'b0, '0, 1'b1, 4'd7, 32'h22222222);
    idle();

    // A write one cycle after the read is not forwarded.
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd7, 32'h33333333);
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, '0, '0);
    idle();

    // R1 grant, idle gap, then contention must favour R0.
    step(1'b0, '0, 1'b1, 4'd4, 1'b0, '0, '0);
    idle();
    idle();
    idle();
    step(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 4'd2, 1'b0, '0, '0);
    idle();

    // Random traffic; requests stay up until granted.
    q0 = 1'b0; q1 = 1'b0; a0 = '0; a1 = '0; age0 = 0; age1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!q0 && $urandom_range(0, 1) == 1) begin q0 = 1'b1; a0 = L'($urandom_range(0, 7)); end
      if (!q1 && $urandom_range(0, 1) == 1) begin q1 = 1'b1; a1 = L'($urandom_range(0, 7)); end
      rst = (i == 200);
      step(q0, a0, q1, a1, $urandom_range(0, 1) == 1, L'($urandom_range(0, 7)), $urandom);
      if (last_g0) q0 = 1'b0;
      if (last_g1) q1 = 1'b0;
      age0 = (q0 && !rst) ? age0 + 1 : 0;
      age1 = (q1 && !rst) ? age1 + 1 : 0;
      check("r0_wait_bound", age0 > 1, 1'b0);
      check("r1_wait_bound", age1 > 1, 1'b0);
    end
    rst = 1'b0;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
